// File: rtl/sram_1rw_port_sched.sv
// Port scheduler for a single 1RW SRAM macro: zero-fills the array after reset, then shares the
// port between one reader and a 1-entry buffered writer, forwarding reads that hit the buffer.
module sram_1rw_port_sched #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 22,
  parameter int unsigned DEPTH         = 256,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned         StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0]  StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]   LastAddr  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic                init_done_q;

  logic                buf_valid_q;
  logic [ADDR_W-1:0]   buf_addr_q;
  logic [DATA_W-1:0]   buf_data_q;
  logic [StarveW-1:0]  starve_q;

  logic                resp_valid_q;
  logic                resp_sram_q;
  logic [DATA_W-1:0]   resp_data_q;

  logic run, starved, rd_acc, rd_fwd, drain, wr_acc;

  // Outputs are forced low while reset_n is asserted, even though INIT drives the port.
  always_comb begin
    run        = reset_n && (state_q == StRun);
    starved    = buf_valid_q && (starve_q == StarveMax);
    rd_ready   = run && !starved;
    rd_acc     = rd_valid && rd_ready;
    rd_fwd     = rd_acc && buf_valid_q && (rd_addr == buf_addr_q);
    drain      = run && buf_valid_q && (starved || !rd_acc || rd_fwd);
    wr_ready   = run && (!buf_valid_q || drain);
    wr_acc     = wr_valid && wr_ready;

    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_wmask = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (reset_n && (state_q == StInit)) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_wmask = 1'b1;
      sram_addr  = init_cnt_q;
    end else if (drain) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_wmask = 1'b1;
      sram_addr  = buf_addr_q;
      sram_wdata = buf_data_q;
    end else if (rd_acc && !rd_fwd) begin
      sram_en    = 1'b1;
      sram_addr  = rd_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT_ON_RESET ? StInit : StRun;
      init_cnt_q  <= '0;
      init_done_q <= !INIT_ON_RESET;
    end else if (state_q == StInit) begin
      init_cnt_q <= init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == LastAddr) begin
        state_q     <= StRun;
        init_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_sram_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if (wr_acc) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= wr_addr;
        buf_data_q  <= wr_data;
      end else if (drain) begin
        buf_valid_q <= 1'b0;
      end

      if (drain) begin
        starve_q <= '0;
      end else if (run && buf_valid_q && (starve_q != StarveMax)) begin
        starve_q <= starve_q + StarveW'(1);
      end

      resp_valid_q <= rd_acc;
      resp_sram_q  <= rd_acc && !rd_fwd;
      // resp_data_q keeps the last delivered value so rd_resp_data holds between responses.
      if (rd_fwd) begin
        resp_data_q <= buf_data_q;
      end else if (resp_valid_q && resp_sram_q) begin
        resp_data_q <= sram_rdata;
      end
    end
  end

  assign init_done     = init_done_q;
  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_data  = (resp_valid_q && resp_sram_q) ? sram_rdata : resp_data_q;

endmodule

// File: tb/tb_sram_1rw_port_sched.sv
// Bench for sram_1rw_port_sched: behavioural SRAM, a logical-memory reference model and
// scenario tasks driven one cycle at a time.
module tb_sram_1rw_port_sched;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 22;
  localparam int DEPTH  = 256;
  localparam int LIMIT  = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done, rd_valid, rd_ready, rd_resp_valid;
  logic              wr_valid, wr_ready, sram_en, sram_wmode, sram_wmask;
  logic [ADDR_W-1:0] rd_addr, wr_addr, sram_addr;
  logic [DATA_W-1:0] rd_resp_data, wr_data, sram_wdata, sram_rdata;

  always #5 clock = ~clock;

  sram_1rw_port_sched dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_addr    (sram_addr),
    .sram_wmask   (sram_wmask),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // SRAM macro model; never-written words read back as a non-zero pattern.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  bit                written  [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        sram_mem[sram_addr] <= sram_wdata;
        written[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= written[sram_addr] ? sram_mem[sram_addr] : (22'h2C3A5 ^ {14'd0, sram_addr});
      end
    end
  end

  int                n_checks = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              m_rv, wp_valid;
  logic [DATA_W-1:0] m_rd, wp_data, last_resp;
  logic [ADDR_W-1:0] wp_addr;
  int                wp_age;

  logic              o_rvalid, o_rready, o_wready, o_en, o_wmode, o_wmask, o_idone;
  logic [DATA_W-1:0] o_rdata, o_wdata, e_rdata, pre_data, pre_last;
  logic [ADDR_W-1:0] o_addr, pre_addr;
  logic              e_rvalid, racc, wacc, drain_obs, pre_pend;
  int                pre_age;

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_rv = 1'b0; m_rd = '0; wp_valid = 1'b0; wp_age = 0; wp_addr = '0; wp_data = '0;
    last_resp = '0;
  endtask

  // One cycle: drive at negedge, sample 1ns later, update the model, wait for the next negedge.
  task automatic step(input logic rv, input logic [ADDR_W-1:0] ra, input logic wv,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    o_rvalid = rd_resp_valid; o_rdata = rd_resp_data; o_rready = rd_ready; o_wready = wr_ready;
    o_en = sram_en; o_wmode = sram_wmode; o_wmask = sram_wmask; o_addr = sram_addr;
    o_wdata = sram_wdata; o_idone = init_done;
    e_rvalid = m_rv; e_rdata = m_rd; pre_last = last_resp;
    pre_pend = wp_valid; pre_age = wp_age; pre_addr = wp_addr; pre_data = wp_data;
    racc = rv && o_rready;
    wacc = wv && o_wready;
    drain_obs = o_idone && o_en && o_wmode;
    // Read-first: the read sees memory before this cycle's write.
    m_rv = racc;
    if (racc) m_rd = ref_mem[ra];
    if (wacc) ref_mem[wa] = wd;
    if (wp_valid && drain_obs) wp_valid = 1'b0;
    else if (wp_valid) wp_age++;
    if (wacc) begin
      wp_valid = 1'b1; wp_addr = wa; wp_data = wd; wp_age = 0;
    end
    if (e_rvalid) last_resp = e_rdata;
    @(negedge clock);
  endtask

  task automatic test_reset();
    rd_valid = 1'b1; rd_addr = 8'h33; wr_valid = 1'b1; wr_addr = 8'h44; wr_data = 22'h3FFFF;
    @(negedge clock);
    n_checks++;
    if ({init_done, rd_ready, rd_resp_valid, rd_resp_data, wr_ready, sram_en, sram_wmode,
         sram_addr, sram_wmask, sram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%b wm=%b addr=%h rdy=%b/%b done=%b rv=%b, want all 0",
               sram_en, sram_wmode, sram_addr, rd_ready, wr_ready, init_done, rd_resp_valid);
    end
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, ADDR_W'($urandom), 1'b1, ADDR_W'($urandom), DATA_W'($urandom));
      n_checks++;
      if ({o_en, o_wmode, o_wmask, o_addr, o_wdata} !== {3'b111, ADDR_W'(i), DATA_W'(0)}) begin
        n_fail++;
        $display("FAIL %s_fill cycle %0d: en=%b wm=%b mask=%b addr=%h wdata=%h, want 1 1 1 %h 0",
                 tag, i, o_en, o_wmode, o_wmask, o_addr, o_wdata, i[7:0]);
      end
      n_checks++;
      if ({o_rready, o_wready, o_idone} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_gate cycle %0d: rd_ready=%b wr_ready=%b init_done=%b, want 0 0 0",
                 tag, i, o_rready, o_wready, o_idone);
      end
    end
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if ({o_idone, o_en, o_wready} !== 3'b101) begin
      n_fail++;
      $display("FAIL %s_done: init_done=%b sram_en=%b wr_ready=%b, want 1 0 1",
               tag, o_idone, o_en, o_wready);
    end
  endtask

  task automatic test_first_read();
    step(1'b1, 8'hA5, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'd0) begin
      n_fail++;
      $display("FAIL read_after_init: valid=%b data=%h, want 1 000000", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_write_drain();
    step(1'b0, '0, 1'b1, 8'h10, 22'h2AAAA);
    n_checks++;
    if (o_wready !== 1'b1 || o_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_accept: wr_ready=%b sram_en=%b, want 1 0", o_wready, o_en);
    end
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if ({o_en, o_wmode, o_wmask, o_addr, o_wdata} !== {3'b111, 8'h10, 22'h2AAAA}) begin
      n_fail++;
      $display("FAIL wr_drain: en=%b wm=%b addr=%h wdata=%h, want 1 1 10 2aaaa",
               o_en, o_wmode, o_addr, o_wdata);
    end
    step(1'b1, 8'h10, 1'b0, '0, '0);
    n_checks++;
    if ({o_rready, o_en, o_wmode, o_addr} !== {3'b110, 8'h10}) begin
      n_fail++;
      $display("FAIL rd_issue: rdy=%b en=%b wm=%b addr=%h, want 1 1 0 10",
               o_rready, o_en, o_wmode, o_addr);
    end
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'h2AAAA) begin
      n_fail++;
      $display("FAIL rd_after_drain: valid=%b data=%h, want 1 2aaaa", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_forward();
    step(1'b0, '0, 1'b1, 8'h20, 22'h1234);
    step(1'b1, 8'h20, 1'b0, '0, '0);
    n_checks++;
    if ({o_rready, o_en, o_wmode, o_addr, o_wdata} !== {3'b111, 8'h20, 22'h1234}) begin
      n_fail++;
      $display("FAIL fwd_port: rdy=%b en=%b wm=%b addr=%h wdata=%h, want 1 1 1 20 1234",
               o_rready, o_en, o_wmode, o_addr, o_wdata);
    end
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'h1234) begin
      n_fail++;
      $display("FAIL fwd_resp: valid=%b data=%h, want 1 1234", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_starve();
    step(1'b1, 8'h01, 1'b1, 8'h40, 22'h55);
    n_checks++;
    if ({racc, wacc} !== 2'b11) begin
      n_fail++;
      $display("FAIL starve_setup: rd_acc=%b wr_acc=%b, want 1 1", racc, wacc);
    end
    for (int k = 1; k <= LIMIT + 2; k++) begin
      step(1'b1, ADDR_W'(k + 1), 1'b0, '0, '0);
      n_checks++;
      if (k == LIMIT + 1) begin
        if ({o_rready, o_en, o_wmode, o_addr, o_wdata} !== {3'b011, 8'h40, 22'h55}) begin
          n_fail++;
          $display("FAIL starve_drain k=%0d: rdy=%b en=%b wm=%b addr=%h, want 0 1 1 40",
                   k, o_rready, o_en, o_wmode, o_addr);
        end
      end else if ({o_rready, o_en, o_wmode, o_addr} !== {3'b110, ADDR_W'(k + 1)}) begin
        n_fail++;
        $display("FAIL starve_read k=%0d: rdy=%b en=%b wm=%b addr=%h, want 1 1 0 %0h",
                 k, o_rready, o_en, o_wmode, o_addr, k + 1);
      end
      n_checks++;
      if (o_rvalid !== e_rvalid || (e_rvalid && o_rdata !== e_rdata)) begin
        n_fail++;
        $display("FAIL starve_resp k=%0d: valid=%b data=%h, want %b %h",
                 k, o_rvalid, o_rdata, e_rvalid, e_rdata);
      end
    end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 8'h30, 1'b1, 8'h30, 22'h7);
    step(1'b1, 8'h30, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'h0) begin
      n_fail++;
      $display("FAIL same_cycle_old: valid=%b data=%h, want 1 0", o_rvalid, o_rdata);
    end
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'h7) begin
      n_fail++;
      $display("FAIL same_cycle_new: valid=%b data=%h, want 1 7", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] datas [4];
    addrs = '{8'h10, 8'h20, 8'h30, 8'h40};
    datas = '{22'h2AAAA, 22'h1234, 22'h7, 22'h55};
    for (int k = 0; k <= 4; k++) begin
      step(k < 4, (k < 4) ? addrs[k] : '0, 1'b0, '0, '0);
      if (k < 4) begin
        n_checks++;
        if (o_rready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready k=%0d: rd_ready=%b, want 1", k, o_rready);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (o_rvalid !== 1'b1 || o_rdata !== datas[k-1]) begin
          n_fail++;
          $display("FAIL b2b_resp k=%0d: valid=%b data=%h, want 1 %h",
                   k, o_rvalid, o_rdata, datas[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h10, 1'b1, 8'h50, 22'h99);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({init_done, rd_ready, rd_resp_valid, rd_resp_data, wr_ready, sram_en, sram_wmode,
         sram_addr, sram_wmask, sram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rv=%b rdata=%h en=%b done=%b, want all 0",
               rd_resp_valid, rd_resp_data, sram_en, init_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();
    test_init("reinit");
    step(1'b1, 8'h50, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    n_checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_write_lost: valid=%b data=%h, want 1 0", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_random();
    logic exp_drain, exp_read;
    for (int i = 0; i < 1500; i++) begin
      step((i < 1498) && ($urandom_range(0, 99) < 70), ADDR_W'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 40, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
      n_checks++;
      if (o_rvalid !== e_rvalid || (e_rvalid && o_rdata !== e_rdata) ||
          (!e_rvalid && o_rdata !== pre_last)) begin
        n_fail++;
        $display("FAIL rand_resp step %0d: valid=%b data=%h, want %b %h (held %h)",
                 i, o_rvalid, o_rdata, e_rvalid, e_rdata, pre_last);
      end
      exp_drain = pre_pend && (pre_age >= LIMIT || !racc || rd_addr == pre_addr);
      exp_read  = racc && !(pre_pend && rd_addr == pre_addr);
      n_checks++;
      if (drain_obs !== exp_drain || (drain_obs && (o_addr !== pre_addr || o_wdata !== pre_data))
          || (exp_read && (o_en !== 1'b1 || o_wmode !== 1'b0 || o_addr !== rd_addr))) begin
        n_fail++;
        $display("FAIL rand_port step %0d: en=%b wm=%b addr=%h wdata=%h, want drain=%b read=%b",
                 i, o_en, o_wmode, o_addr, o_wdata, exp_drain, exp_read);
      end
      n_checks++;
      if (o_rready !== !(pre_pend && pre_age >= LIMIT) || o_wready !== (!pre_pend || exp_drain))
      begin
        n_fail++;
        $display("FAIL rand_ready step %0d: rd_ready=%b wr_ready=%b, age=%0d pend=%b",
                 i, o_rready, o_wready, pre_age, pre_pend);
      end
    end
  endtask

  initial begin
    rd_valid = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_model();
    test_reset();
    test_init("init");
    test_first_read();
    test_write_drain();
    test_forward();
    test_starve();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
